// File: rtl/event_seq_checker.sv
// event_seq_checker: fires NUM_EVENTS one-cycle strobes in index order and scores the handler acks.
// Optional EVSEQ_STRICT_ORDER_EN: an ack ahead of its own fire, or any ack in PRE, is an error.
module event_seq_checker #(
    parameter int NUM_EVENTS = 2,
    parameter int CNT_W      = 8,
    parameter int START_CYC  = 2,
    parameter int GAP        = 1,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_EVENTS-1:0] ack,
    output logic [NUM_EVENTS-1:0] fire,
    output logic [NUM_EVENTS-1:0] triggered,
    output logic [CNT_W-1:0]      cyc,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int                    IDX_W     = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_EVENTS - 1);
    localparam logic [NUM_EVENTS-1:0] ALL_ONES  = '1;
    // PRE includes the cycle after the start sample, so fire[0] lands START_CYC+1 cycles later.
    localparam logic [31:0]           PRE_END   = 32'(START_CYC);
    localparam logic [31:0]           SPACE_END = 32'(GAP - 2);
    localparam logic [31:0]           CHK_END   = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_FIRE, S_SPACE, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [31:0]           tmr, tmr_nxt;
    logic [NUM_EVENTS-1:0] trig_nxt;
    logic [NUM_EVENTS-1:0] mask_now;
`ifdef EVSEQ_STRICT_ORDER_EN
    logic [NUM_EVENTS-1:0] issued;
    logic [NUM_EVENTS-1:0] early;
`endif

    assign busy  = (state == S_PRE) || (state == S_FIRE) || (state == S_SPACE) || (state == S_CHK);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch behind.
        state_nxt = state;
        idx_nxt   = idx;
        tmr_nxt   = tmr + 32'd1;
        trig_nxt  = triggered;
        fire      = '0;
        mask_now  = triggered | ack;
`ifdef EVSEQ_STRICT_ORDER_EN
        for (int j = 0; j < NUM_EVENTS; j++) begin
            issued[j] = (j < int'(idx)) || ((j == int'(idx)) && (state != S_PRE));
        end
        early = ack & ~issued;
`endif

        case (state)
            S_IDLE: begin
                tmr_nxt = '0;
                if (start) begin
                    state_nxt = S_PRE;
                    idx_nxt   = '0;
                    trig_nxt  = '0;
                end
            end
            S_PRE: begin
                trig_nxt = mask_now;
                if (tmr == PRE_END) begin
                    tmr_nxt   = '0;
                    state_nxt = (mask_now != '0) ? S_ERR : S_FIRE;
                end
            end
            S_FIRE: begin
                fire[idx] = 1'b1;
                trig_nxt  = mask_now;
                tmr_nxt   = '0;
                if (idx == LAST_IDX) begin
                    state_nxt = S_CHK;
                end else if (GAP == 1) begin
                    idx_nxt = idx + 1'b1;
                end else begin
                    state_nxt = S_SPACE;
                end
            end
            S_SPACE: begin
                trig_nxt = mask_now;
                if (tmr == SPACE_END) begin
                    state_nxt = S_FIRE;
                    idx_nxt   = idx + 1'b1;
                end
            end
            S_CHK: begin
                // This cycle's ack counts, so a last-moment ack beats the timeout.
                trig_nxt = mask_now;
                if (mask_now == ALL_ONES) begin
                    state_nxt = S_DONE;
                end else if (tmr == CHK_END) begin
                    state_nxt = S_ERR;
                end
            end
            default: tmr_nxt = tmr;
        endcase

`ifdef EVSEQ_STRICT_ORDER_EN
        if (busy && (early != '0)) begin
            state_nxt = S_ERR;
        end
`endif
        // A reset cycle never shows a strobe, even if the state register still says FIRE.
        if (rst) begin
            fire = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            tmr       <= '0;
            triggered <= '0;
            cyc       <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            tmr       <= tmr_nxt;
            triggered <= trig_nxt;
            if ((state == S_IDLE) && start) begin
                cyc <= '0;
            end else if (busy && (cyc != '1)) begin
                cyc <= cyc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_event_seq_checker.sv
// Scoreboard bench for event_seq_checker: three parameterisations, directed stimulus,
// expected fire strobes and end-of-sequence results queued and checked by negedge monitors.
module tb_event_seq_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b, start_c;
    logic [1:0] ack_a, ack_c;
    logic [3:0] ack_b;

    logic [1:0] fire_a, trig_a;
    logic [7:0] cyc_a;
    logic       busy_a, done_a, error_a;
    logic [3:0] fire_b, trig_b;
    logic [7:0] cyc_b;
    logic       busy_b, done_b, error_b;
    logic [1:0] fire_c, trig_c;
    logic [1:0] cyc_c;
    logic       busy_c, done_c, error_c;

    event_seq_checker u_a (
        .clk(clk), .rst(rst), .start(start_a), .ack(ack_a), .fire(fire_a),
        .triggered(trig_a), .cyc(cyc_a), .busy(busy_a), .done(done_a), .error(error_a)
    );

    event_seq_checker #(.NUM_EVENTS(4), .GAP(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .ack(ack_b), .fire(fire_b),
        .triggered(trig_b), .cyc(cyc_b), .busy(busy_b), .done(done_b), .error(error_b)
    );

    event_seq_checker #(.CNT_W(2), .START_CYC(5)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .ack(ack_c), .fire(fire_c),
        .triggered(trig_c), .cyc(cyc_c), .busy(busy_c), .done(done_c), .error(error_c)
    );

    typedef struct {
        int          id;
        bit          is_end;
        logic [31:0] fire;
        logic [31:0] cyc;
        logic        done;
        logic        error;
        logic [31:0] trig;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_fire(input int id, input logic [31:0] f, input logic [31:0] c);
        exp_t e;
        e = '{id: id, is_end: 1'b0, fire: f, cyc: c, done: 1'b0, error: 1'b0, trig: '0};
        exp_q.push_back(e);
    endtask

    task automatic exp_end(input int id, input logic d, input logic er,
                           input logic [31:0] t, input logic [31:0] c);
        exp_t e;
        e = '{id: id, is_end: 1'b1, fire: '0, cyc: c, done: d, error: er, trig: t};
        exp_q.push_back(e);
    endtask

    task automatic observe(input int id, input bit is_end, input logic [31:0] f,
                           input logic [31:0] c, input logic d, input logic er,
                           input logic [31:0] t);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: dut %0d end=%0b fire=%0h cyc=%0d, expected nothing",
                     id, is_end, f, c);
        end else begin
            e = exp_q.pop_front();
            check("dut_id", 32'(id), 32'(e.id));
            check("event_kind", 32'(is_end), 32'(e.is_end));
            if (!e.is_end) begin
                check("fire", f, e.fire);
                check("fire_cyc", c, e.cyc);
            end else begin
                check("done", 32'(d), 32'(e.done));
                check("error", 32'(er), 32'(e.error));
                check("triggered", t, e.trig);
                check("end_cyc", c, e.cyc);
            end
        end
    endtask

    logic term_a = 1'b0, term_b = 1'b0, term_c = 1'b0;

    always @(negedge clk) begin
        if (fire_a != '0) observe(0, 1'b0, 32'(fire_a), 32'(cyc_a), 1'b0, 1'b0, '0);
        if ((done_a || error_a) && !term_a)
            observe(0, 1'b1, '0, 32'(cyc_a), done_a, error_a, 32'(trig_a));
        term_a <= done_a || error_a;
    end

    always @(negedge clk) begin
        if (fire_b != '0) observe(1, 1'b0, 32'(fire_b), 32'(cyc_b), 1'b0, 1'b0, '0);
        if ((done_b || error_b) && !term_b)
            observe(1, 1'b1, '0, 32'(cyc_b), done_b, error_b, 32'(trig_b));
        term_b <= done_b || error_b;
    end

    always @(negedge clk) begin
        if (fire_c != '0) observe(2, 1'b0, 32'(fire_c), 32'(cyc_c), 1'b0, 1'b0, '0);
        if ((done_c || error_c) && !term_c)
            observe(2, 1'b1, '0, 32'(cyc_c), done_c, error_c, 32'(trig_c));
        term_c <= done_c || error_c;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Leaves the bench one step into cycle 0 (first PRE cycle, cyc == 0).
    task automatic do_start(input int id);
        start_a = (id == 0);
        start_b = (id == 1);
        start_c = (id == 2);
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        wait_cycles(4);
    endtask

    // Four fires at cyc 3,6,9,12; ack k driven lag cycles after fire k.
    task automatic run_b(input int lag);
        exp_fire(1, 32'h1, 3);
        exp_fire(1, 32'h2, 6);
        exp_fire(1, 32'h4, 9);
        exp_fire(1, 32'h8, 12);
        exp_end(1, 1'b1, 1'b0, 32'hF, 14);
        do_start(1);
        wait_cycles(3 + lag);
        for (int k = 0; k < 4; k++) begin
            ack_b = 4'(1 << k);
            tick();
            ack_b = '0;
            if (k < 3) wait_cycles(2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        ack_a = '0; ack_b = '0; ack_c = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_fire", 32'(fire_a), 32'd0);
        check("rst_triggered", 32'(trig_a), 32'd0);
        check("rst_cyc", 32'(cyc_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_error", 32'(error_a), 32'd0);

        // Acks one cycle after each fire: clean pass.
        exp_fire(0, 32'h1, 3);
        exp_fire(0, 32'h2, 4);
        exp_end(0, 1'b1, 1'b0, 32'h3, 6);
        do_start(0);
        check("busy_after_start", 32'(busy_a), 32'd1);
        check("cyc_after_start", 32'(cyc_a), 32'd0);
        wait_cycles(4);
        ack_a = 2'b01;
        tick();
        ack_a = 2'b10;
        tick();
        ack_a = '0;
        drain("drain_pass");

        // ack[1] missing: error exactly TIMEOUT cycles after CHK entry.
        do_reset();
        exp_fire(0, 32'h1, 3);
        exp_fire(0, 32'h2, 4);
        exp_end(0, 1'b0, 1'b1, 32'h1, 9);
        do_start(0);
        wait_cycles(4);
        ack_a = 2'b01;
        tick();
        ack_a = '0;
        drain("drain_timeout");

        // ack[0] held through PRE: no fire, error.
        do_reset();
`ifdef EVSEQ_STRICT_ORDER_EN
        exp_end(0, 1'b0, 1'b1, 32'h1, 1);
`else
        exp_end(0, 1'b0, 1'b1, 32'h1, 3);
`endif
        do_start(0);
        ack_a = 2'b01;
        wait_cycles(3);
        ack_a = '0;
        drain("drain_pre_ack");

        // Four channels, GAP 3, acks in the fire cycle.
        do_reset();
        run_b(0);
        drain("drain_gap3");

        // Reset while in SPACE, then a clean pass.
        do_reset();
        exp_fire(1, 32'h1, 3);
        do_start(1);
        wait_cycles(4);
        rst = 1'b1;
        tick();
        check("midrst_fire", 32'(fire_b), 32'd0);
        check("midrst_triggered", 32'(trig_b), 32'd0);
        check("midrst_cyc", 32'(cyc_b), 32'd0);
        check("midrst_busy", 32'(busy_b), 32'd0);
        check("midrst_done", 32'(done_b), 32'd0);
        check("midrst_error", 32'(error_b), 32'd0);
        rst = 1'b0;
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_b(1);
        drain("drain_after_rst");

        // ack[1] early, in the fire[0] cycle.
        do_reset();
        exp_fire(0, 32'h1, 3);
`ifdef EVSEQ_STRICT_ORDER_EN
        exp_end(0, 1'b0, 1'b1, 32'h3, 4);
`else
        exp_fire(0, 32'h2, 4);
        exp_end(0, 1'b1, 1'b0, 32'h3, 6);
`endif
        do_start(0);
        wait_cycles(3);
        ack_a = 2'b11;
        tick();
        ack_a = '0;
        drain("drain_early_ack");

        // 2-bit cycle counter saturates at 3 while the sequence still passes.
        do_reset();
        exp_fire(2, 32'h1, 3);
        exp_fire(2, 32'h2, 3);
        exp_end(2, 1'b1, 1'b0, 32'h3, 3);
        do_start(2);
        wait_cycles(7);
        ack_c = 2'b01;
        tick();
        ack_c = 2'b10;
        tick();
        ack_c = '0;
        drain("drain_sat");
        check("cyc_saturated", 32'(cyc_c), 32'd3);
        check("done_sticky", 32'(done_c), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
